// File: rtl/chunk_head_arb.sv
// Round-robin arbiter that lets N_SRC requesters share one ChunkHead.
// A granted request is latched into the o_* payload, which is then held until ChunkHead acks the run.
module chunk_head_arb #(
  parameter int N_SRC   = 2,
  parameter int SRC_BW  = $clog2(N_SRC),
  parameter int WBW     = 16,
  parameter int VDIM    = 3,
  parameter int ICFG_BW = 8
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst,
  input  logic [N_SRC-1:0]                       i_req_rdy,
  output logic [N_SRC-1:0]                       i_req_ack,
  input  logic [N_SRC-1:0][VDIM-1:0][WBW-1:0]    i_req_bofs,
  input  logic [N_SRC-1:0][VDIM-1:0][WBW-1:0]    i_req_aofs,
  input  logic [N_SRC-1:0][ICFG_BW-1:0]          i_req_beg,
  input  logic [N_SRC-1:0][ICFG_BW-1:0]          i_req_end,
  output logic                                   o_abofs_rdy,
  input  logic                                   o_abofs_ack,
  output logic [VDIM-1:0][WBW-1:0]               o_bofs,
  output logic [VDIM-1:0][WBW-1:0]               o_aofs,
  output logic [ICFG_BW-1:0]                     o_beg,
  output logic [ICFG_BW-1:0]                     o_end,
  output logic [SRC_BW-1:0]                      o_src
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state;
  logic [SRC_BW-1:0] ptr;
  logic              live;
  logic [N_SRC-1:0]  empty;
  logic [SRC_BW-1:0] sel;
  logic              sel_valid;
  logic [SRC_BW:0]   idx;
  logic              grant;

  function automatic logic [SRC_BW-1:0] wrap_inc(input logic [SRC_BW-1:0] v);
    return (v == SRC_BW'(N_SRC - 1)) ? '0 : v + 1'b1;
  endfunction

  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
      assign empty[gi]     = (i_req_beg[gi] >= i_req_end[gi]);
      assign i_req_ack[gi] = grant && (sel == SRC_BW'(gi));
    end
  endgenerate

  // Scan from the highest offset down so the source nearest ptr wins.
  always_comb begin
    sel_valid = 1'b0;
    sel       = '0;
    idx       = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (SRC_BW + 1)'(k);
      if (idx >= (SRC_BW + 1)'(N_SRC))
        idx = idx - (SRC_BW + 1)'(N_SRC);
      if (i_req_rdy[idx[SRC_BW-1:0]]) begin
        sel_valid = 1'b1;
        sel       = idx[SRC_BW-1:0];
      end
    end
  end

  // live keeps acks off during reset and in the first cycle after release.
  assign grant = live && i_rst && (state == IDLE) && sel_valid;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state       <= IDLE;
      ptr         <= '0;
      live        <= 1'b0;
      o_abofs_rdy <= 1'b0;
      o_src       <= '0;
      o_bofs      <= '0;
      o_aofs      <= '0;
      o_beg       <= '0;
      o_end       <= '0;
    end else begin
      live <= 1'b1;
      case (state)
        IDLE: begin
          if (grant) begin
            if (empty[sel]) begin
              ptr <= wrap_inc(sel);
            end else begin
              state       <= BUSY;
              o_abofs_rdy <= 1'b1;
              o_bofs      <= i_req_bofs[sel];
              o_aofs      <= i_req_aofs[sel];
              o_beg       <= i_req_beg[sel];
              o_end       <= i_req_end[sel];
              o_src       <= sel;
            end
          end
        end
        BUSY: begin
          if (o_abofs_ack) begin
            state       <= IDLE;
            o_abofs_rdy <= 1'b0;
            ptr         <= wrap_inc(o_src);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chunk_head_arb.sv
// Randomized bench for chunk_head_arb at N_SRC=2 and N_SRC=3, checked cycle by cycle
// against a queue-free reference that applies the round-robin grant rules directly.
module tb_chunk_head_arb;
  localparam int VDIM    = 2;
  localparam int WBW     = 8;
  localparam int ICFG_BW = 3;
  localparam int NCYC    = 4000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [7:0]                          rdy    [2];
  logic [7:0][VDIM-1:0][WBW-1:0]       bofs   [2];
  logic [7:0][VDIM-1:0][WBW-1:0]       aofs   [2];
  logic [7:0][ICFG_BW-1:0]             beg    [2];
  logic [7:0][ICFG_BW-1:0]             endv   [2];
  logic [1:0]                          ab_ack;

  logic [1:0]               ack_a;
  logic                     ordy_a;
  logic [VDIM-1:0][WBW-1:0] obofs_a, oaofs_a;
  logic [ICFG_BW-1:0]       obeg_a, oend_a;
  logic [0:0]               osrc_a;
  logic [2:0]               ack_b;
  logic                     ordy_b;
  logic [VDIM-1:0][WBW-1:0] obofs_b, oaofs_b;
  logic [ICFG_BW-1:0]       obeg_b, oend_b;
  logic [1:0]               osrc_b;

  chunk_head_arb #(.N_SRC(2), .WBW(WBW), .VDIM(VDIM), .ICFG_BW(ICFG_BW)) u_arb2 (
    .i_clk(clk), .i_rst(rst_n),
    .i_req_rdy(rdy[0][1:0]), .i_req_ack(ack_a),
    .i_req_bofs(bofs[0][1:0]), .i_req_aofs(aofs[0][1:0]),
    .i_req_beg(beg[0][1:0]), .i_req_end(endv[0][1:0]),
    .o_abofs_rdy(ordy_a), .o_abofs_ack(ab_ack[0]),
    .o_bofs(obofs_a), .o_aofs(oaofs_a), .o_beg(obeg_a), .o_end(oend_a), .o_src(osrc_a)
  );

  chunk_head_arb #(.N_SRC(3), .WBW(WBW), .VDIM(VDIM), .ICFG_BW(ICFG_BW)) u_arb3 (
    .i_clk(clk), .i_rst(rst_n),
    .i_req_rdy(rdy[1][2:0]), .i_req_ack(ack_b),
    .i_req_bofs(bofs[1][2:0]), .i_req_aofs(aofs[1][2:0]),
    .i_req_beg(beg[1][2:0]), .i_req_end(endv[1][2:0]),
    .o_abofs_rdy(ordy_b), .o_abofs_ack(ab_ack[1]),
    .o_bofs(obofs_b), .o_aofs(oaofs_b), .o_beg(obeg_b), .o_end(oend_b), .o_src(osrc_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference state: what ChunkHead should currently be seeing from each arbiter.
  bit                       m_busy [2];
  int                       m_ptr  [2];
  int                       m_src  [2];
  logic [VDIM-1:0][WBW-1:0] m_bofs [2];
  logic [VDIM-1:0][WBW-1:0] m_aofs [2];
  logic [ICFG_BW-1:0]       m_beg  [2];
  logic [ICFG_BW-1:0]       m_end  [2];
  bit                       live;
  bit                       drop   [2];
  int                       drop_src [2];

  initial begin
    int rst_cnt;
    int p_req, p_ack, phase, n, sel;
    logic [7:0] exp_ack, got_ack;
    logic got_rdy;
    logic [VDIM-1:0][WBW-1:0] got_bofs, got_aofs;
    logic [ICFG_BW-1:0] got_beg, got_end;
    logic [1:0] got_src;

    rst_n  = 1'b0;
    ab_ack = '0;
    for (int i = 0; i < 2; i++) begin
      rdy[i] = '0; bofs[i] = '0; aofs[i] = '0; beg[i] = '0; endv[i] = '0;
      m_busy[i] = 0; m_ptr[i] = 0; m_src[i] = 0;
      m_bofs[i] = '0; m_aofs[i] = '0; m_beg[i] = '0; m_end[i] = '0;
      drop[i] = 0; drop_src[i] = 0;
    end
    live    = 0;
    rst_cnt = 2;
    @(posedge clk); #1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      phase = (cyc < 1500) ? 0 : (cyc < 2500) ? 1 : 2;
      p_req = (phase == 0) ? 30 : (phase == 1) ? 100 : 60;
      p_ack = (phase == 0) ? 30 : (phase == 1) ? 50 : 3;

      if (rst_cnt > 0) begin
        rst_n = 1'b0;
        rst_cnt--;
      end else if (phase != 1 && $urandom_range(0, 199) == 0) begin
        rst_n   = 1'b0;
        rst_cnt = $urandom_range(0, 2);
      end else begin
        rst_n = 1'b1;
      end

      for (int i = 0; i < 2; i++) begin
        n = (i == 0) ? 2 : 3;
        if (drop[i]) begin
          rdy[i][drop_src[i]] = 1'b0;
          drop[i] = 0;
        end
        for (int s = 0; s < n; s++) begin
          if (!rdy[i][s]) begin
            // Idle sources may change payload freely, which also exercises hold-while-busy.
            bofs[i][s] = VDIM*WBW'($urandom);
            aofs[i][s] = VDIM*WBW'($urandom);
            beg[i][s]  = ICFG_BW'($urandom_range(0, 4));
            endv[i][s] = ICFG_BW'($urandom_range(0, 5));
            if ($urandom_range(0, 99) < p_req) rdy[i][s] = 1'b1;
          end
        end
        ab_ack[i] = m_busy[i] && ($urandom_range(0, 99) < p_ack);
      end

      #1;
      for (int i = 0; i < 2; i++) begin
        n = (i == 0) ? 2 : 3;
        sel = -1;
        if (rst_n && live && !m_busy[i])
          for (int k = 0; k < n; k++)
            if (sel < 0 && rdy[i][(m_ptr[i] + k) % n]) sel = (m_ptr[i] + k) % n;
        exp_ack = '0;
        if (sel >= 0) exp_ack[sel] = 1'b1;

        if (i == 0) begin
          got_ack = {6'b0, ack_a}; got_rdy = ordy_a; got_src = {1'b0, osrc_a};
          got_bofs = obofs_a; got_aofs = oaofs_a; got_beg = obeg_a; got_end = oend_a;
        end else begin
          got_ack = {5'b0, ack_b}; got_rdy = ordy_b; got_src = osrc_b;
          got_bofs = obofs_b; got_aofs = oaofs_b; got_beg = obeg_b; got_end = oend_b;
        end

        check($sformatf("n%0d c%0d ack", n, cyc), 64'(got_ack), 64'(exp_ack));
        check($sformatf("n%0d c%0d abofs_rdy", n, cyc), 64'(got_rdy), 64'(m_busy[i]));
        check($sformatf("n%0d c%0d src", n, cyc), 64'(got_src), 64'(m_src[i]));
        check($sformatf("n%0d c%0d bofs", n, cyc), 64'(got_bofs), 64'(m_bofs[i]));
        check($sformatf("n%0d c%0d aofs", n, cyc), 64'(got_aofs), 64'(m_aofs[i]));
        check($sformatf("n%0d c%0d beg", n, cyc), 64'(got_beg), 64'(m_beg[i]));
        check($sformatf("n%0d c%0d end", n, cyc), 64'(got_end), 64'(m_end[i]));

        if (!rst_n) begin
          m_busy[i] = 0; m_ptr[i] = 0; m_src[i] = 0;
          m_bofs[i] = '0; m_aofs[i] = '0; m_beg[i] = '0; m_end[i] = '0;
        end else if (sel >= 0) begin
          drop[i]     = 1;
          drop_src[i] = sel;
          $display("grant n=%0d cyc=%0d src=%0d beg=%0d end=%0d", n, cyc, sel, beg[i][sel], endv[i][sel]);
          if (beg[i][sel] >= endv[i][sel]) begin
            m_ptr[i] = (sel + 1) % n;
          end else begin
            m_busy[i] = 1;
            m_src[i]  = sel;
            m_bofs[i] = bofs[i][sel];
            m_aofs[i] = aofs[i][sel];
            m_beg[i]  = beg[i][sel];
            m_end[i]  = endv[i][sel];
          end
        end else if (m_busy[i] && ab_ack[i]) begin
          m_busy[i] = 0;
          m_ptr[i]  = (m_src[i] + 1) % n;
        end
      end
      live = rst_n;

      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chunk_head_arb.md
CHUNK_HEAD_ARB -- requirements
Module: chunk_head_arb

Interface
REQ-001 Parameter N_SRC, default 2: number of requesters sharing one ChunkHead; legal range 2..8.
REQ-002 Parameter SRC_BW, default $clog2(N_SRC): width of the source tag.
REQ-003 Widths WBW, VDIM and ICFG_BW SHALL come from TauCfg, as for ChunkHead.
REQ-004 i_clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 i_rst  input  1  reset, synchronous, active-low.
REQ-006 i_req_rdy  input  [N_SRC]  per-source request valid.
REQ-007 i_req_ack  output  [N_SRC]  per-source request accept, one-hot or zero.
REQ-008 i_req_bofs  input  [N_SRC][VDIM] x WBW  per-source block offsets.
REQ-009 i_req_aofs  input  [N_SRC][VDIM] x WBW  per-source accumulation offsets.
REQ-010 i_req_beg  input  [N_SRC] x ICFG_BW  first config id.
REQ-011 i_req_end  input  [N_SRC] x ICFG_BW  one past last config id.
REQ-012 o_abofs_rdy  output  1  request valid toward ChunkHead i_abofs.
REQ-013 o_abofs_ack  input  1  ChunkHead accept; pulses with the ack of the last o_mofs of a run.
REQ-014 o_bofs, o_aofs  output  [VDIM] x WBW  registered payload to ChunkHead.
REQ-015 o_beg, o_end  output  ICFG_BW  registered payload to ChunkHead.
REQ-016 o_src  output  SRC_BW  tag of the source owning the current run, for downstream routing.

Function
REQ-017 Handshake: a transfer on any rdy/ack pair SHALL occur only in a cycle where both rdy and ack are high; once raised, rdy SHALL stay high with stable payload until ack.
REQ-018 The FSM SHALL have two states: IDLE and BUSY.
REQ-019 IDLE arbitration SHALL be round-robin: scan sources ptr, ptr+1, ..., mod N_SRC, and select the first with i_req_rdy high.
REQ-020 An empty request (i_req_beg >= i_req_end, unsigned) selected in IDLE SHALL be acked that cycle, not forwarded; FSM stays IDLE; ptr becomes sel+1 mod N_SRC.
REQ-021 A non-empty request selected in IDLE SHALL be acked that cycle.
REQ-022 On that ack, its bofs/aofs/beg/end SHALL be latched into o_* and sel into o_src; FSM goes to BUSY.
REQ-023 o_abofs_rdy SHALL equal (state == BUSY); it is registered, so the first rdy appears one cycle after the grant.
REQ-024 In BUSY, o_bofs/o_aofs/o_beg/o_end/o_src SHALL hold stable, and i_req_ack SHALL be all zero.
REQ-025 In BUSY with o_abofs_ack high: next state IDLE; ptr becomes o_src+1 mod N_SRC; o_src holds its value until the next grant.
REQ-026 At least one IDLE cycle SHALL separate consecutive runs, so the back-to-back grant-to-grant minimum is 2 cycles plus the ChunkHead run length.
REQ-027 At most one i_req_ack bit SHALL be high per cycle.
REQ-028 If no i_req_rdy bit is high in IDLE, state and ptr SHALL hold.
REQ-029 A request deasserting before ack is a protocol violation and is not handled.
REQ-030 The wrap of ptr from N_SRC-1 to 0 SHALL be exact for non-power-of-two N_SRC.

Reset
REQ-031 While i_rst is low at a clock edge:
- state = IDLE, ptr = 0
- o_abofs_rdy = 0, i_req_ack = 0
- o_src = 0, o_bofs/o_aofs/o_beg/o_end = 0
REQ-032 Reset asserted mid-run (BUSY) SHALL abandon the run with no ack to any requester; the source must re-request after reset.
REQ-033 i_req_ack and o_abofs_rdy SHALL be low in the first cycle after reset release.

Verification
REQ-034 Single source, N_SRC=2: src0 beg=0 end=3; ChunkHead acks after 3 mofs -> i_req_ack[0] in cycle 0, o_abofs_rdy from cycle 1, o_src=0, IDLE after o_abofs_ack, ptr=1.
REQ-035 Fairness: both sources hold rdy continuously, each with beg=1 end=2 -> grants alternate 0,1,0,1; no source granted twice in a row.
REQ-036 Empty request: src1 beg=2 end=2, src0 idle -> i_req_ack[1] in one cycle, o_abofs_rdy never rises; beg=3 end=1 gives the same result.
REQ-037 Stability: during BUSY, vary src0 inputs and hold o_abofs_ack low for 20 cycles -> o_* and o_src constant; i_req_ack stays 0.
REQ-038 Reset mid-run: assert i_rst while BUSY with o_src=1 -> next cycle o_abofs_rdy=0, o_src=0, ptr=0; no ack issued.
REQ-039 Wrap, N_SRC=3: ptr=2, sources 0 and 2 rdy -> src2 granted first, then src0, after which ptr=1.
